mlp_digit_classifier: RTL and testbench
=======================================

// Module: mlp_digit_classifier
// PURPOSE
//  Two-layer fully-connected integer classifier (ANN reference path of the SNN/ANN comparison).
//  - Sequentially MACs an input vector through 10 hidden ReLU neurons.
//  - Then through 10 output neurons, and reports the 10 class scores plus the winning class index.
//  - Softmax is a separate downstream combinational block, outside this module.
//  - Argmax on raw scores equals argmax on softmax.
// PARAMETERS
//  LAYER1_NEURON_WIDTH  823   upper index of input/w1 arrays (arrays are [0:LAYER1_NEURON_WIDTH])
//  LAYER1_COUNTER_END   820   last input index consumed by layer 1; higher indices ignored
//  LAYER1_BITS          31    hidden activation width minus 1 (h is LAYER1_BITS+1 bits signed)
//  LAYER2_NEURON_WIDTH  49    upper index of w2 arrays
//  LAYER2_COUNTER_END   40    last index consumed by layer 2
//  LAYER2_BITS          LAYER1_BITS+8   score width is LAYER2_BITS+25 (=64 default)
// PORTS
//  One clock; reset is synchronous and active-high.
//  clk            in   1      rising-edge clock
//  rst            in   1      synchronous reset, active-high
//  data_in        in   32 x [0:LAYER1_NEURON_WIDTH]   signed input vector, held stable
//  w1_1..w1_10    in   32 x [0:LAYER1_NEURON_WIDTH]   signed hidden-neuron j weights
//  b1             in   32 x [0:9]     signed hidden biases
//  w2_1..w2_10    in   32 x [0:LAYER2_NEURON_WIDTH]   signed output-neuron j weights
//  b2             in   64 x [0:9]     signed output biases
//  neuralnet_out  out  LAYER2_BITS+25 x [0:9]  signed class scores
//  max_index      out  4      index of largest score
//  done           out  1      scores/max_index valid
// BEHAVIOUR
//  - Reset: all outputs, accumulators and the counter go to 0; state goes to L1_ACC.
//  - Reset applies on any cycle, including mid-run; the block restarts from k=0 afterwards.
//  - State flow: L1_ACC -> L1_ACT -> L2_ACC -> L2_OUT -> DONE. DONE holds until rst.
//  - Start is automatic: the first edge with rst low is L1_ACC, k=0.
//  - L1_ACC: each edge, acc1[j] += data_in[k]*w1_j[k] for all 10 j in parallel.
//    - Products are 64b signed; acc1 is 74b signed (cannot overflow).
//    - k runs 0..LAYER1_COUNTER_END (821 edges).
//  - L1_ACT (1 edge): h[j] = max(0, acc1[j] + sext(b1[j])), saturated to 2^LAYER1_BITS - 1.
//  - L2_ACC: acc2[j] += x[k]*w2_j[k] for k = 0..LAYER2_COUNTER_END (41 edges).
//    - x[k] = h[k] for k<10; x[k] = 0 for k>=10 (zero padding; those weights have no effect).
//  - L2_OUT (1 edge): neuralnet_out[j] = sat_{LAYER2_BITS+25}(acc2[j] + sext(b2[j])).
//    - max_index is registered from those values on the same edge.
//    - done rises on the same edge.
//  - Latency: done = 1 exactly LAYER1_COUNTER_END + LAYER2_COUNTER_END + 4 edges after the
//    first edge with rst low (864 default).
//  - Before done: neuralnet_out = 0, max_index = 0.
//  - Argmax: signed compare; ties resolve to the lowest index.
//  - Saturation: clamp to the max/min signed value of the target width; never wrap.
//  - Inputs changing mid-run: the term for index k uses the value present on that edge.
//    No input capture.
// STRUCTURE
//  - Shared package: NUM_CLASSES=10, DATA_W=32, BIAS2_W=64, state enum {L1_ACC, L1_ACT,
//    L2_ACC, L2_OUT, DONE}, saturate function.
//  - Natural sub-module: argmax10 (combinational, 10 signed scores -> 4b index, lowest index
//    wins ties).
//  - Single shared k counter for both layers.
//  - 10 parallel MAC lanes in a generate loop.
// TESTING
//  - All data/weights/b1 = 0, b2[j] = 100*j -> done at edge 864, out[j] = 100*j, max_index = 9.
//  - data_in[0] = 1, w1_j[0] = j+1, w2_j[k] = (k==j), biases 0 -> out[j] = j+1, max_index = 9.
//  - ReLU: data_in[0] = 1, w1_1[0] = -5, w2_1[0] = 1 -> h[0] = 0, out[0] = 0;
//    b1[3] = -7, all else 0 -> out = 0.
//  - Ties: b2 = {5,9,9,0,...} -> max_index = 1; all scores equal -> max_index = 0.
//  - Padding: w1_j[821..823] = 1000, w2_j[10..49] = 1000, data_in all 1 -> no effect on
//    outputs vs zeroed padding.
//  - Reset mid-run: assert rst for 1 edge at edge 400 -> outputs and done go to 0 at once;
//    done returns exactly 864 edges after release with identical results.

Source files
------------

// File: rtl/mlp_digit_classifier_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mlp_digit_classifier_pkg
// Description : Shared constants, FSM state type and saturation helper for
//               the integer MLP digit classifier.
// Revision    : 1.0 - initial release
// ============================================================================
package mlp_digit_classifier_pkg;

    localparam int NUM_CLASSES = 10;
    localparam int DATA_W      = 32;
    localparam int BIAS2_W     = 64;
    localparam int SAT_W       = 128;

    typedef enum logic [2:0] {
        L1_ACC = 3'd0,
        L1_ACT = 3'd1,
        L2_ACC = 3'd2,
        L2_OUT = 3'd3,
        DONE   = 3'd4
    } state_t;

    // Clamp a wide signed value into the signed range of 'width' bits.
    function automatic logic signed [SAT_W-1:0] saturate(
        input logic signed [SAT_W-1:0] value,
        input int unsigned             width
    );
        logic signed [SAT_W-1:0] max_v;
        logic signed [SAT_W-1:0] min_v;
        max_v = $signed((SAT_W'(1) << (width - 1)) - SAT_W'(1));
        min_v = ~max_v;
        if (value > max_v) return max_v;
        if (value < min_v) return min_v;
        return value;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mlp_digit_classifier_argmax10.sv
`default_nettype none
// ============================================================================
// Module      : mlp_digit_classifier_argmax10
// Description : Combinational argmax over 10 signed scores; lowest index wins.
// Revision    : 1.0 - initial release
// ============================================================================
module mlp_digit_classifier_argmax10
    import mlp_digit_classifier_pkg::*;
#(
    parameter int SCORE_W = 64
) (
    input  logic signed [SCORE_W-1:0] scores [0:NUM_CLASSES-1],
    output logic        [3:0]         max_index
);

    logic signed [SCORE_W-1:0] w_best_val;

    // Strict greater-than keeps the earlier index on ties.
    always_comb begin
        w_best_val = scores[0];
        max_index  = 4'd0;
        for (int i = 1; i < NUM_CLASSES; i++) begin
            if (scores[i] > w_best_val) begin
                w_best_val = scores[i];
                max_index  = 4'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mlp_digit_classifier.sv
`default_nettype none
// ============================================================================
// Module      : mlp_digit_classifier
// Description : Two-layer integer MLP: 10 ReLU hidden neurons, 10 output
//               scores and the winning class index, computed sequentially.
// Revision    : 1.0 - initial release
// ============================================================================
module mlp_digit_classifier
    import mlp_digit_classifier_pkg::*;
#(
    parameter int LAYER1_NEURON_WIDTH = 823,
    parameter int LAYER1_COUNTER_END  = 820,
    parameter int LAYER1_BITS         = 31,
    parameter int LAYER2_NEURON_WIDTH = 49,
    parameter int LAYER2_COUNTER_END  = 40,
    parameter int LAYER2_BITS         = LAYER1_BITS + 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic signed [DATA_W-1:0]      data_in [0:LAYER1_NEURON_WIDTH],
    input  logic signed [DATA_W-1:0]      w1_1    [0:LAYER1_NEURON_WIDTH],
    input  logic signed [DATA_W-1:0]      w1_2    [0:LAYER1_NEURON_WIDTH],
    input  logic signed [DATA_W-1:0]      w1_3    [0:LAYER1_NEURON_WIDTH],
    input  logic signed [DATA_W-1:0]      w1_4    [0:LAYER1_NEURON_WIDTH],
    input  logic signed [DATA_W-1:0]      w1_5    [0:LAYER1_NEURON_WIDTH],
    input  logic signed [DATA_W-1:0]      w1_6    [0:LAYER1_NEURON_WIDTH],
    input  logic signed [DATA_W-1:0]      w1_7    [0:LAYER1_NEURON_WIDTH],
    input  logic signed [DATA_W-1:0]      w1_8    [0:LAYER1_NEURON_WIDTH],
    input  logic signed [DATA_W-1:0]      w1_9    [0:LAYER1_NEURON_WIDTH],
    input  logic signed [DATA_W-1:0]      w1_10   [0:LAYER1_NEURON_WIDTH],
    input  logic signed [DATA_W-1:0]      b1      [0:NUM_CLASSES-1],
    input  logic signed [DATA_W-1:0]      w2_1    [0:LAYER2_NEURON_WIDTH],
    input  logic signed [DATA_W-1:0]      w2_2    [0:LAYER2_NEURON_WIDTH],
    input  logic signed [DATA_W-1:0]      w2_3    [0:LAYER2_NEURON_WIDTH],
    input  logic signed [DATA_W-1:0]      w2_4    [0:LAYER2_NEURON_WIDTH],
    input  logic signed [DATA_W-1:0]      w2_5    [0:LAYER2_NEURON_WIDTH],
    input  logic signed [DATA_W-1:0]      w2_6    [0:LAYER2_NEURON_WIDTH],
    input  logic signed [DATA_W-1:0]      w2_7    [0:LAYER2_NEURON_WIDTH],
    input  logic signed [DATA_W-1:0]      w2_8    [0:LAYER2_NEURON_WIDTH],
    input  logic signed [DATA_W-1:0]      w2_9    [0:LAYER2_NEURON_WIDTH],
    input  logic signed [DATA_W-1:0]      w2_10   [0:LAYER2_NEURON_WIDTH],
    input  logic signed [BIAS2_W-1:0]     b2      [0:NUM_CLASSES-1],
    output logic signed [LAYER2_BITS+24:0] neuralnet_out [0:NUM_CLASSES-1],
    output logic        [3:0]             max_index,
    output logic                          done
);

    localparam int H_W     = LAYER1_BITS + 1;
    localparam int SCORE_W = LAYER2_BITS + 25;
    localparam int P1_W    = 2 * DATA_W;
    localparam int ACC1_W  = P1_W + 10;
    localparam int SUM1_W  = ACC1_W + 1;
    localparam int P2_W    = H_W + DATA_W;
    localparam int ACC2_W  = SCORE_W + 8;
    localparam int SUM2_W  = ACC2_W + 1;
    localparam int K_W     = $clog2(LAYER1_NEURON_WIDTH + 1);
    localparam int K2_W    = $clog2(LAYER2_NEURON_WIDTH + 1);

    state_t                     r_state;
    logic        [K_W-1:0]      r_k;
    logic signed [ACC1_W-1:0]   r_acc1 [0:NUM_CLASSES-1];
    logic signed [H_W-1:0]      r_h    [0:NUM_CLASSES-1];
    logic signed [ACC2_W-1:0]   r_acc2 [0:NUM_CLASSES-1];

    logic        [K2_W-1:0]     w_k2;
    logic signed [DATA_W-1:0]   w_data_k;
    logic signed [H_W-1:0]      w_x;
    logic signed [DATA_W-1:0]   w_w1_k      [0:NUM_CLASSES-1];
    logic signed [DATA_W-1:0]   w_w2_k      [0:NUM_CLASSES-1];
    logic signed [ACC1_W-1:0]   w_acc1_next [0:NUM_CLASSES-1];
    logic signed [SUM1_W-1:0]   w_pre_h     [0:NUM_CLASSES-1];
    logic signed [H_W-1:0]      w_h_next    [0:NUM_CLASSES-1];
    logic signed [ACC2_W-1:0]   w_acc2_next [0:NUM_CLASSES-1];
    logic signed [SUM2_W-1:0]   w_score_sum [0:NUM_CLASSES-1];
    logic signed [SCORE_W-1:0]  w_score     [0:NUM_CLASSES-1];
    logic        [3:0]          w_argmax;

    assign w_k2     = r_k[K2_W-1:0];
    assign w_data_k = data_in[r_k];
    // Layer-2 inputs beyond the 10 hidden neurons are zero padding.
    assign w_x      = (r_k < K_W'(NUM_CLASSES)) ? r_h[r_k[3:0]] : '0;

    assign w_w1_k[0] = w1_1[r_k];   assign w_w2_k[0] = w2_1[w_k2];
    assign w_w1_k[1] = w1_2[r_k];   assign w_w2_k[1] = w2_2[w_k2];
    assign w_w1_k[2] = w1_3[r_k];   assign w_w2_k[2] = w2_3[w_k2];
    assign w_w1_k[3] = w1_4[r_k];   assign w_w2_k[3] = w2_4[w_k2];
    assign w_w1_k[4] = w1_5[r_k];   assign w_w2_k[4] = w2_5[w_k2];
    assign w_w1_k[5] = w1_6[r_k];   assign w_w2_k[5] = w2_6[w_k2];
    assign w_w1_k[6] = w1_7[r_k];   assign w_w2_k[6] = w2_7[w_k2];
    assign w_w1_k[7] = w1_8[r_k];   assign w_w2_k[7] = w2_8[w_k2];
    assign w_w1_k[8] = w1_9[r_k];   assign w_w2_k[8] = w2_9[w_k2];
    assign w_w1_k[9] = w1_10[r_k];  assign w_w2_k[9] = w2_10[w_k2];

    for (genvar j = 0; j < NUM_CLASSES; j++) begin : g_lane
        assign w_acc1_next[j] = r_acc1[j]
                              + ACC1_W'(P1_W'(w_data_k) * P1_W'(w_w1_k[j]));
        assign w_pre_h[j]     = SUM1_W'(r_acc1[j]) + SUM1_W'(b1[j]);
        assign w_h_next[j]    = (w_pre_h[j] < 0) ? '0
                              : H_W'(saturate(SAT_W'(w_pre_h[j]), H_W));
        assign w_acc2_next[j] = r_acc2[j]
                              + ACC2_W'(P2_W'(w_x) * P2_W'(w_w2_k[j]));
        assign w_score_sum[j] = SUM2_W'(r_acc2[j]) + SUM2_W'(b2[j]);
        assign w_score[j]     = SCORE_W'(saturate(SAT_W'(w_score_sum[j]), SCORE_W));
    end

    mlp_digit_classifier_argmax10 #(
        .SCORE_W (SCORE_W)
    ) u_argmax (
        .scores    (w_score),
        .max_index (w_argmax)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= L1_ACC;
            r_k       <= '0;
            done      <= 1'b0;
            max_index <= '0;
            for (int j = 0; j < NUM_CLASSES; j++) begin
                r_acc1[j]        <= '0;
                r_h[j]           <= '0;
                r_acc2[j]        <= '0;
                neuralnet_out[j] <= '0;
            end
        end else begin
            case (r_state)
                L1_ACC: begin
                    for (int j = 0; j < NUM_CLASSES; j++) r_acc1[j] <= w_acc1_next[j];
                    if (r_k == K_W'(LAYER1_COUNTER_END)) begin
                        r_k     <= '0;
                        r_state <= L1_ACT;
                    end else begin
                        r_k <= r_k + K_W'(1);
                    end
                end
                L1_ACT: begin
                    for (int j = 0; j < NUM_CLASSES; j++) r_h[j] <= w_h_next[j];
                    r_state <= L2_ACC;
                end
                L2_ACC: begin
                    for (int j = 0; j < NUM_CLASSES; j++) r_acc2[j] <= w_acc2_next[j];
                    if (r_k == K_W'(LAYER2_COUNTER_END)) begin
                        r_k     <= '0;
                        r_state <= L2_OUT;
                    end else begin
                        r_k <= r_k + K_W'(1);
                    end
                end
                L2_OUT: begin
                    for (int j = 0; j < NUM_CLASSES; j++) neuralnet_out[j] <= w_score[j];
                    max_index <= w_argmax;
                    done      <= 1'b1;
                    r_state   <= DONE;
                end
                DONE:    r_state <= DONE;
                default: r_state <= L1_ACC;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mlp_digit_classifier.sv
`default_nettype none
// ============================================================================
// Module      : tb_mlp_digit_classifier
// Description : Directed self-checking bench for mlp_digit_classifier.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mlp_digit_classifier;

    localparam int N1      = 824;
    localparam int N2      = 50;
    localparam int LATENCY = 864;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic signed [31:0] data_in [0:N1-1];
    logic signed [31:0] w1_1 [0:N1-1], w1_2 [0:N1-1], w1_3 [0:N1-1], w1_4 [0:N1-1], w1_5 [0:N1-1];
    logic signed [31:0] w1_6 [0:N1-1], w1_7 [0:N1-1], w1_8 [0:N1-1], w1_9 [0:N1-1], w1_10 [0:N1-1];
    logic signed [31:0] w2_1 [0:N2-1], w2_2 [0:N2-1], w2_3 [0:N2-1], w2_4 [0:N2-1], w2_5 [0:N2-1];
    logic signed [31:0] w2_6 [0:N2-1], w2_7 [0:N2-1], w2_8 [0:N2-1], w2_9 [0:N2-1], w2_10 [0:N2-1];
    logic signed [31:0] b1 [0:9];
    logic signed [63:0] b2 [0:9];
    logic signed [63:0] neuralnet_out [0:9];
    logic        [3:0]  max_index;
    logic               done;

    int errors = 0;
    int checks = 0;
    logic signed [63:0] exp_s [0:9];
    logic signed [63:0] q_scores [$];
    logic        [3:0]  q_idx [$];

    always #5 clk = ~clk;

    mlp_digit_classifier dut (
        .clk (clk), .rst (rst), .data_in (data_in),
        .w1_1 (w1_1), .w1_2 (w1_2), .w1_3 (w1_3), .w1_4 (w1_4), .w1_5 (w1_5),
        .w1_6 (w1_6), .w1_7 (w1_7), .w1_8 (w1_8), .w1_9 (w1_9), .w1_10 (w1_10),
        .b1 (b1),
        .w2_1 (w2_1), .w2_2 (w2_2), .w2_3 (w2_3), .w2_4 (w2_4), .w2_5 (w2_5),
        .w2_6 (w2_6), .w2_7 (w2_7), .w2_8 (w2_8), .w2_9 (w2_9), .w2_10 (w2_10),
        .b2 (b2),
        .neuralnet_out (neuralnet_out), .max_index (max_index), .done (done)
    );

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_w1(input int j, input int k, input logic signed [31:0] v);
        case (j)
            0: w1_1[k] = v;  1: w1_2[k] = v;  2: w1_3[k] = v;  3: w1_4[k] = v;  4: w1_5[k] = v;
            5: w1_6[k] = v;  6: w1_7[k] = v;  7: w1_8[k] = v;  8: w1_9[k] = v;  default: w1_10[k] = v;
        endcase
    endtask

    task automatic set_w2(input int j, input int k, input logic signed [31:0] v);
        case (j)
            0: w2_1[k] = v;  1: w2_2[k] = v;  2: w2_3[k] = v;  3: w2_4[k] = v;  4: w2_5[k] = v;
            5: w2_6[k] = v;  6: w2_7[k] = v;  7: w2_8[k] = v;  8: w2_9[k] = v;  default: w2_10[k] = v;
        endcase
    endtask

    task automatic clear_all();
        for (int k = 0; k < N1; k++) begin
            data_in[k] = '0;
            for (int j = 0; j < 10; j++) set_w1(j, k, 32'sd0);
        end
        for (int k = 0; k < N2; k++)
            for (int j = 0; j < 10; j++) set_w2(j, k, 32'sd0);
        for (int j = 0; j < 10; j++) begin
            b1[j]    = '0;
            b2[j]    = '0;
            exp_s[j] = '0;
        end
    endtask

    task automatic push_expected(input int idx);
        for (int j = 0; j < 10; j++) q_scores.push_back(exp_s[j]);
        q_idx.push_back(4'(idx));
    endtask

    task automatic check_cleared(input string tag);
        chk({tag, " done"}, done, 0);
        chk({tag, " max_index"}, max_index, 0);
        for (int j = 0; j < 10; j++)
            chk($sformatf("%s zero out[%0d]", tag, j), neuralnet_out[j], 0);
    endtask

    task automatic wait_and_compare(input string tag);
        int n;
        logic signed [63:0] e;
        logic [3:0] ei;
        n = 0;
        while (done !== 1'b1 && n < 2000) begin
            @(posedge clk);
            n++;
            #1;
        end
        chk({tag, " latency"}, n, LATENCY);
        for (int j = 0; j < 10; j++) begin
            e = q_scores.pop_front();
            chk($sformatf("%s out[%0d]", tag, j), neuralnet_out[j], e);
        end
        ei = q_idx.pop_front();
        chk({tag, " max_index"}, max_index, ei);
    endtask

    task automatic run_test(input string tag);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_cleared({tag, " rst"});
        rst = 1'b0;
        wait_and_compare(tag);
    endtask

    task automatic setup_diag();
        data_in[0] = 32'sd1;
        for (int j = 0; j < 10; j++) begin
            set_w1(j, 0, 32'(j + 1));
            set_w2(j, j, 32'sd1);
            exp_s[j] = 64'(j + 1);
        end
    endtask

    initial begin
        clear_all();

        // Biases only
        for (int j = 0; j < 10; j++) begin
            b2[j]    = 64'(100 * j);
            exp_s[j] = 64'(100 * j);
        end
        push_expected(9);
        run_test("bias");
        repeat (5) @(posedge clk);
        #1;
        chk("bias hold done", done, 1);
        chk("bias hold out[9]", neuralnet_out[9], 900);

        // Identity second layer
        clear_all();
        setup_diag();
        push_expected(9);
        run_test("diag");

        // ReLU clipping on both weights and bias
        clear_all();
        data_in[0] = 32'sd1;
        set_w1(0, 0, -32'sd5);
        set_w2(0, 0, 32'sd1);
        b1[3] = -32'sd7;
        set_w2(3, 3, 32'sd1);
        set_w1(1, 0, 32'sd3);
        set_w2(1, 1, 32'sd1);
        exp_s[1] = 64'sd3;
        push_expected(1);
        run_test("relu");

        // Ties between equal maxima
        clear_all();
        b2[0] = 64'sd5; b2[1] = 64'sd9; b2[2] = 64'sd9;
        exp_s[0] = 64'sd5; exp_s[1] = 64'sd9; exp_s[2] = 64'sd9;
        push_expected(1);
        run_test("tie");

        clear_all();
        for (int j = 0; j < 10; j++) begin
            b2[j]    = 64'sd7;
            exp_s[j] = 64'sd7;
        end
        push_expected(0);
        run_test("alleq");

        // Padding indices must not contribute
        clear_all();
        setup_diag();
        for (int k = 0; k < N1; k++) data_in[k] = 32'sd1;
        for (int j = 0; j < 10; j++) begin
            for (int k = 821; k < N1; k++) set_w1(j, k, 32'sd1000);
            for (int k = 10; k < N2; k++) set_w2(j, k, 32'sd1000);
        end
        push_expected(9);
        run_test("pad");

        // Saturation of hidden activation and both score extremes
        clear_all();
        data_in[0] = 32'sh7FFF_FFFF;
        data_in[1] = 32'sh7FFF_FFFF;
        data_in[2] = 32'sd1;
        set_w1(2, 0, 32'sh7FFF_FFFF);
        set_w1(2, 1, 32'sh7FFF_FFFF);
        set_w1(0, 2, 32'sd1);
        set_w1(1, 2, 32'sd1);
        set_w2(0, 0, 32'sd1);
        set_w2(1, 1, -32'sd1);
        set_w2(2, 2, 32'sd1);
        b2[0] = 64'sh7FFF_FFFF_FFFF_FFFF;
        b2[1] = 64'sh8000_0000_0000_0000;
        exp_s[0] = 64'sh7FFF_FFFF_FFFF_FFFF;
        exp_s[1] = 64'sh8000_0000_0000_0000;
        exp_s[2] = 64'sd2147483647;
        push_expected(0);
        run_test("sat");

        // Reset pulse in the middle of layer 1
        clear_all();
        setup_diag();
        push_expected(9);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_cleared("mid pre");
        rst = 1'b0;
        repeat (399) @(posedge clk);
        #1;
        chk("mid run done", done, 0);
        chk("mid run out[9]", neuralnet_out[9], 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_cleared("mid post");
        rst = 1'b0;
        wait_and_compare("mid");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
